// File: rtl/demux_32_bit_buf.sv
// demux_32_bit_buf
// 1-to-2 buffered demultiplexer. A single producer stream is steered by
// in_control into one of two independent FIFOs. Each FIFO has its own
// valid/ready consumer port, so a stalled sink blocks only its own traffic.
//
// Build option: define DEMUX_STATS_EN to add acc0_cnt / acc1_cnt. These are
// saturating 16-bit counters of words accepted into each channel.
module demux_32_bit_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_control,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out0_valid,
    output logic [WIDTH-1:0] out0_data,
    input  logic             out0_ready,
    output logic             out1_valid,
    output logic [WIDTH-1:0] out1_data,
    input  logic             out1_ready,
    output logic             busy
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]      acc0_cnt,
    output logic [15:0]      acc1_cnt
`endif
);

    // DEPTH is a power of two, so pointers of this width wrap modulo DEPTH
    // without any explicit compare.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Per-channel status gathered from the generate blocks below.
    logic [1:0]       ch_full;
    logic [1:0]       ch_valid;
    logic [1:0]       ch_push;
    logic [1:0]       ch_pop;
    logic [1:0]       sink_ready;
    logic [WIDTH-1:0] ch_data [2];

    // Accepted push this cycle; it lands in exactly one channel.
    logic push;

    assign sink_ready = {out1_ready, out0_ready};

    // The full flag of a channel blocks the producer even if that channel
    // pops on the same edge: there is no push-through when full. in_ready
    // never looks at in_valid.
    assign in_ready = ~ch_full[in_control];
    assign push     = in_valid & in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic [WIDTH-1:0] mem [DEPTH];
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [CNT_W-1:0] count_reg;
            logic             sel;

            // Channel 0 is selected by in_control == 0, channel 1 by 1.
            assign sel         = (gi == 0) ? ~in_control : in_control;
            assign ch_push[gi] = push & sel;

            // Popping an empty channel is ignored.
            assign ch_pop[gi]   = ch_valid[gi] & sink_ready[gi];
            assign ch_valid[gi] = (count_reg != '0);
            assign ch_full[gi]  = (count_reg == CNT_FULL);

            // The head word is read straight out of storage so a word written
            // at edge k is visible right after that edge; when empty the data
            // port is forced to zero rather than exposing a stale entry.
            assign ch_data[gi] = ch_valid[gi] ? mem[rd_ptr_reg] : '0;

            // Storage write; contents need no reset because they are masked
            // by the valid flag until written.
            always_ff @(posedge clk) begin
                if (ch_push[gi]) begin
                    mem[wr_ptr_reg] <= in_data;
                end
            end

            // Write pointer advances on every accepted push into this channel.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_reg <= '0;
                end else if (ch_push[gi]) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                end
            end

            // Read pointer advances on every pop of a non-empty channel.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_ptr_reg <= '0;
                end else if (ch_pop[gi]) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                end
            end

            // Occupancy: push-only grows, pop-only shrinks, both together
            // leave it unchanged.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else begin
                    case ({ch_push[gi], ch_pop[gi]})
                        2'b10:   count_reg <= count_reg + CNT_ONE;
                        2'b01:   count_reg <= count_reg - CNT_ONE;
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    assign out0_valid = ch_valid[0];
    assign out0_data  = ch_data[0];
    assign out1_valid = ch_valid[1];
    assign out1_data  = ch_data[1];

    // Busy whenever any word is still held in either channel.
    assign busy = |ch_valid;

`ifdef DEMUX_STATS_EN
    logic [15:0] acc_cnt [2];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_stats
            logic [15:0] acc_reg;

            // Count accepted pushes on the same edge as the push, holding at
            // all-ones instead of wrapping.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                end else if (ch_push[gi] && (acc_reg != 16'hFFFF)) begin
                    acc_reg <= acc_reg + 16'd1;
                end
            end

            assign acc_cnt[gi] = acc_reg;
        end
    endgenerate

    assign acc0_cnt = acc_cnt[0];
    assign acc1_cnt = acc_cnt[1];
`endif

endmodule

// File: tb/tb_demux_32_bit_buf.sv
// Self-checking bench for demux_32_bit_buf. Accepted pushes are recorded in a
// per-channel expected queue; every pop seen on an output port is compared
// against the front of the matching queue. Scenario tasks add their own
// direct checks on handshake, status and boundary behaviour.
module tb_demux_32_bit_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_control;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out0_valid;
    logic [31:0] out0_data;
    logic        out0_ready;
    logic        out1_valid;
    logic [31:0] out1_data;
    logic        out1_ready;
    logic        busy;
`ifdef DEMUX_STATS_EN
    logic [15:0] acc0_cnt;
    logic [15:0] acc1_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    always #5 clk = ~clk;

    demux_32_bit_buf #(.WIDTH(32), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_control (in_control),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready),
        .busy       (busy)
`ifdef DEMUX_STATS_EN
        ,
        .acc0_cnt   (acc0_cnt),
        .acc1_cnt   (acc1_cnt)
`endif
    );

    // Scoreboard: inputs only change just after a rising edge, so at the
    // falling edge they show exactly what the next rising edge will see.
    always @(negedge clk) begin
        logic [31:0] exp_w;
        if (rst_n) begin
            if (out0_valid && out0_ready) begin
                total++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL sb0 got=%h required=<no word expected>", out0_data);
                end else begin
                    exp_w = q0.pop_front();
                    if (out0_data !== exp_w) begin
                        bad++;
                        $display("FAIL sb0 got=%h required=%h", out0_data, exp_w);
                    end
                end
            end
            if (out1_valid && out1_ready) begin
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL sb1 got=%h required=<no word expected>", out1_data);
                end else begin
                    exp_w = q1.pop_front();
                    if (out1_data !== exp_w) begin
                        bad++;
                        $display("FAIL sb1 got=%h required=%h", out1_data, exp_w);
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (in_control) q1.push_back(in_data);
                else            q0.push_back(in_data);
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        cyc();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        in_control = 1'b0;
        in_data    = 32'hDEADBEEF;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        cyc();
        cyc();
        total++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b%b required=00", out1_valid, out0_valid);
        end
        total++;
        if (out0_data !== 32'h0 || out1_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h required=0/0", out0_data, out1_data);
        end
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_status busy=%b in_ready=%b required busy=0 in_ready=1", busy, in_ready);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_nopush busy=%b required=0", busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_routing();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_control = 1'b0;
        in_data    = 32'h11111111;
        cyc();
        in_control = 1'b1;
        in_data    = 32'h22222222;
        total++;
        if (out0_valid !== 1'b1 || out0_data !== 32'h11111111 || out1_valid !== 1'b0) begin
            bad++;
            $display("FAIL route0 v0=%b d0=%h v1=%b required v0=1 d0=11111111 v1=0", out0_valid, out0_data, out1_valid);
        end
        cyc();
        in_valid = 1'b0;
        total++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b1 || out1_data !== 32'h22222222) begin
            bad++;
            $display("FAIL route1 v0=%b v1=%b d1=%h required v0=0 v1=1 d1=22222222", out0_valid, out1_valid, out1_data);
        end
        cyc();
        total++;
        if (out1_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL route_drain v1=%b busy=%b required v1=0 busy=0", out1_valid, busy);
        end
        $display("test_routing done");
    endtask

    task automatic test_full_block();
        out0_ready = 1'b0;
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_control = 1'b0;
        in_data    = 32'hA0;
        cyc();
        in_data = 32'hA1;
        cyc();
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_ready0 got=%b required=0", in_ready);
        end
        in_valid   = 1'b0;
        in_control = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_ready1 got=%b required=1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = 32'hB0;
        cyc();
        total++;
        if (out1_valid !== 1'b1 || out1_data !== 32'hB0) begin
            bad++;
            $display("FAIL full_push1 v1=%b d1=%h required v1=1 d1=000000b0", out1_valid, out1_data);
        end
        in_control = 1'b0;
        in_data    = 32'hA2;
        cyc();
        total++;
        if (in_ready !== 1'b0 || out0_data !== 32'hA0) begin
            bad++;
            $display("FAIL full_stall in_ready=%b d0=%h required in_ready=0 d0=000000a0", in_ready, out0_data);
        end
        out0_ready = 1'b1;
        cyc();
        total++;
        if (out0_data !== 32'hA1 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_pop1 d0=%h in_ready=%b required d0=000000a1 in_ready=1", out0_data, in_ready);
        end
        cyc();
        in_valid = 1'b0;
        total++;
        if (out0_valid !== 1'b1 || out0_data !== 32'hA2) begin
            bad++;
            $display("FAIL full_pushpop v0=%b d0=%h required v0=1 d0=000000a2", out0_valid, out0_data);
        end
        cyc();
        total++;
        if (out0_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL full_drain v0=%b busy=%b required v0=0 busy=0", out0_valid, busy);
        end
        $display("test_full_block done");
    endtask

    task automatic test_back_to_back();
        int errs;
        errs       = 0;
        out0_ready = 1'b1;
        in_control = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            cyc();
            if (out0_valid !== 1'b1 || in_ready !== 1'b1 || out0_data !== 32'(i)) errs++;
        end
        in_valid = 1'b0;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL b2b_stream bad_cycles=%0d required=0", errs);
        end
        cyc();
        total++;
        if (out0_valid !== 1'b0 || q0.size() != 0) begin
            bad++;
            $display("FAIL b2b_end v0=%b queued=%0d required v0=0 queued=0", out0_valid, q0.size());
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_random();
        logic stall;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            stall = in_valid && !in_ready;
            cyc();
            if (!stall) begin
                in_valid   = ($urandom_range(0, 3) != 0);
                in_control = $urandom_range(0, 1);
                in_data    = $urandom;
            end
            out0_ready = ($urandom_range(0, 2) != 0);
            out1_ready = ($urandom_range(0, 3) == 0);
        end
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        for (int k = 0; k < 10 && busy; k++) cyc();
        total++;
        if (busy !== 1'b0 || q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL rand_drain busy=%b q0=%0d q1=%0d required 0/0/0", busy, q0.size(), q1.size());
        end
        $display("test_random done");
    endtask

    task automatic test_mid_reset();
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        in_control = 1'b1;
        in_data    = 32'h77;
        cyc();
        in_data = 32'h78;
        cyc();
        in_valid = 1'b0;
        total++;
        if (out1_valid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mr_setup v1=%b busy=%b required 1/1", out1_valid, busy);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (out1_valid !== 1'b0 || busy !== 1'b0 || out1_data !== 32'h0) begin
            bad++;
            $display("FAIL mr_async v1=%b busy=%b d1=%h required 0/0/0", out1_valid, busy, out1_data);
        end
        #1;
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        cyc();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL mr_release busy=%b required=0", busy);
        end
        in_valid   = 1'b1;
        in_data    = 32'h5;
        out1_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        total++;
        if (out1_valid !== 1'b1 || out1_data !== 32'h5) begin
            bad++;
            $display("FAIL mr_first v1=%b d1=%h required v1=1 d1=00000005", out1_valid, out1_data);
        end
        cyc();
        total++;
        if (out1_valid !== 1'b0) begin
            bad++;
            $display("FAIL mr_drain v1=%b required=0", out1_valid);
        end
        $display("test_mid_reset done");
    endtask

`ifdef DEMUX_STATS_EN
    task automatic test_stats();
        apply_reset();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_control = (i == 2);
            in_data    = 32'h100 + i;
            cyc();
        end
        in_valid = 1'b0;
        total++;
        if (acc0_cnt !== 16'd3 || acc1_cnt !== 16'd1) begin
            bad++;
            $display("FAIL stats_count acc0=%0d acc1=%0d required 3/1", acc0_cnt, acc1_cnt);
        end
        in_valid   = 1'b1;
        in_control = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            in_data = i;
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        total++;
        if (acc0_cnt !== 16'hFFFF || acc1_cnt !== 16'd1) begin
            bad++;
            $display("FAIL stats_sat acc0=%h acc1=%h required ffff/0001", acc0_cnt, acc1_cnt);
        end
        $display("test_stats done");
    endtask
`endif

    initial begin
        test_reset();
        test_routing();
        test_full_block();
        test_back_to_back();
        test_random();
        test_mid_reset();
`ifdef DEMUX_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Time limit so a stuck design can never hang the run.
    initial begin
        #3000000;
        $display("FAIL timeout got=<still running> required=<finished>");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/demux_32_bit_buf.md
Name: demux_32_bit_buf

Overview:
- 1-to-2 buffered demultiplexer. This is the steering counterpart of the 32-bit 2:1 select mux: one 32-bit producer word is routed to one of two consumers.
- Used on the CPU store/writeback path to split one result stream between two sinks, e.g. data memory (channel 0) and the MMIO/LED/segment block (channel 1).
- Each destination has its own small FIFO with valid/ready handshake. A stalled sink blocks only traffic addressed to it.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per channel FIFO; power of 2, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word this cycle.
- in_control  input  1  destination select: 0 = channel 0, 1 = channel 1.
- in_data  input  WIDTH  producer word.
- in_ready  output  1  selected channel can accept this cycle.
- out0_valid  output  1  channel 0 head word available.
- out0_data  output  WIDTH  channel 0 head word.
- out0_ready  input  1  channel 0 consumer accepts.
- out1_valid  output  1  channel 1 head word available.
- out1_data  output  WIDTH  channel 1 head word.
- out1_ready  input  1  channel 1 consumer accepts.
- busy  output  1  either FIFO non-empty.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state: both FIFOs empty, read/write pointers 0, counts 0. Output values during and after reset:
  - out0_valid = out1_valid = 0
  - out0_data = out1_data = 0
  - busy = 0
  - in_ready = 1
- Reset asserted mid-operation discards all stored words immediately (asynchronously). No partial transfer completes on the edge of reset release.
- in_ready is combinational: in_ready = ~full[in_control]. It depends on in_control and FIFO state only, never on in_valid.
- Push: on a rising edge with in_valid && in_ready, in_data is written into FIFO[in_control]. At most one push per cycle, into one channel only.
- Pop, per channel: on a rising edge with outN_valid && outN_ready, the head entry is removed. Both channels may pop in the same cycle.
- outN_valid = (countN != 0).
- outN_data = head entry when outN_valid, else forced to 0.
- Latency: a word accepted at edge k appears on outN at edge k (visible in cycle k+1). There is no same-cycle combinational bypass from in_data to outN_data.
- Count width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH. count increments on push-only, decrements on pop-only, and is unchanged on simultaneous push+pop to the same channel.
- Full channel: in_ready = 0 even if that channel pops in the same cycle. There is no push-through-when-full. The word stalls and the producer must hold in_valid, in_control and in_data stable until accepted.
- Empty channel: outN_ready has no effect; no pointer movement.
- Push to one channel while popping the other: both happen independently.
- Ordering: FIFO order is preserved per channel. No ordering is guaranteed across channels.
- Producer changing in_control while in_valid is high and in_ready is low is a protocol violation. Behaviour is undefined beyond keeping FIFO integrity.
- busy = (count0 != 0) | (count1 != 0), combinational from registered counts.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- When defined, add two output ports, acc0_cnt and acc1_cnt, each 16 bits.
  - Each counts pushes accepted into its channel.
  - Counters saturate at 16'hFFFF.
  - Both reset to 0 on rst_n.
  - A counter increments on the same edge as the push it records.
- When not defined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset check: hold rst_n low, drive in_valid = 1 with in_data = 32'hDEADBEEF → no push. Outputs: out0_valid = out1_valid = 0, both outN_data = 0, busy = 0, in_ready = 1.
- Routing: push 32'h11111111 with control 0, then 32'h22222222 with control 1; both outN_ready = 1 → out0_data = 32'h11111111 one cycle after its push, out1_data = 32'h22222222 one cycle after its push; each valid for exactly one cycle.
- Full and blocking: out0_ready = 0; push 32'hA0, 32'hA1, then attempt 32'hA2 to channel 0.
  - After 2 pushes: in_ready = 0 for control 0; in_ready = 1 when control is switched to 1, and a push of 32'hB0 to channel 1 succeeds.
  - Raise out0_ready → read 32'hA0, then 32'hA1, then 32'hA2, in order.
- Simultaneous push+pop on channel 0 at count 1 → count stays 1; data order preserved across a pointer wrap (20 continuous words 0..19).
- Mid-operation reset: with 2 words queued in channel 1, pulse rst_n low between clock edges → out1_valid drops immediately; after release busy = 0 and the next push of 32'h5 is the first word read.
- DEMUX_STATS_EN build:
  - 3 pushes to channel 0 and 1 push to channel 1 → acc0_cnt = 3, acc1_cnt = 1.
  - Force 65540 pushes into a channel → that channel's counter holds 16'hFFFF.
